stage_execute_muldiv: RTL and testbench

Multi-cycle RV32M functional unit for the execute stage, generalised to `XLEN` width and `NUM_FWD` bypass sources. It accepts one multiply/divide/remainder operation through a valid/ready handshake and resolves operand forwarding when the operation is accepted. Multiplies complete after a fixed latency; divides use an iterative restoring algorithm. The result is held until the downstream EX/MEM register takes it. The unit sits beside the single-cycle ALU and asserts `out_busy` so the hazard logic stalls IF/ID/EX while an operation is in flight.

---
 rtl/stage_execute_muldiv_if.sv | 36 +++
 rtl/stage_execute_muldiv.sv | 156 +++++++++++++++
 tb/tb_stage_execute_muldiv.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/stage_execute_muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M unit:
// operands plus bypass sources in, one held result out (valid/ready both ways).
interface stage_execute_muldiv_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [2:0]                in_funct3;
  logic [4:0]                in_rs1;
  logic [4:0]                in_rs2;
  logic [XLEN-1:0]           in_data_rs1;
  logic [XLEN-1:0]           in_data_rs2;
  logic [4:0]                in_rd;
  logic [5*NUM_FWD-1:0]      in_fwd_rd;
  logic [NUM_FWD-1:0]        in_fwd_we;
  logic [XLEN*NUM_FWD-1:0]   in_fwd_data;
  logic                      in_flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_result;
  logic [4:0]                out_rd;
  logic                      out_busy;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_data_rs1, in_data_rs2, in_rd,
           in_fwd_rd, in_fwd_we, in_fwd_data, in_flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_busy
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_data_rs1, in_data_rs2, in_rd,
           in_fwd_rd, in_fwd_we, in_fwd_data, in_flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_busy
  );
endinterface

// File: rtl/stage_execute_muldiv.sv
// Iterative RV32M unit: MUL_LAT-cycle multiply, XLEN+1-cycle restoring divide, 2-cycle divide corner cases.
// One op in flight; result held in DONE until out_ready, in_ready only in IDLE without flush.
module stage_execute_muldiv #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  stage_execute_muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN + MUL_LAT + 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] quot_q, rem_q, result_q;
  logic [CW-1:0]   cnt;
  logic            q_neg, r_neg;

  // Lowest index wins, so walk from the oldest source up and let younger ones overwrite.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]              rs,
    input logic [XLEN-1:0]         rf,
    input logic [5*NUM_FWD-1:0]    frd,
    input logic [NUM_FWD-1:0]      fwe,
    input logic [XLEN*NUM_FWD-1:0] fdat
  );
    logic [XLEN-1:0] v;
    v = rf;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwe[i] && (frd[5*i +: 5] == rs) && (rs != 5'd0)) v = fdat[XLEN*i +: XLEN];
    end
    return v;
  endfunction

  logic            accept;
  logic [XLEN-1:0] rs1_val, rs2_val, dvd_mag_in;
  logic            div_signed_in, dvd_neg_in, div_zero, div_ovf, special;

  assign accept        = bus.in_valid && bus.in_ready;
  assign rs1_val       = fwd_sel(bus.in_rs1, bus.in_data_rs1, bus.in_fwd_rd, bus.in_fwd_we, bus.in_fwd_data);
  assign rs2_val       = fwd_sel(bus.in_rs2, bus.in_data_rs2, bus.in_fwd_rd, bus.in_fwd_we, bus.in_fwd_data);
  assign div_signed_in = !bus.in_funct3[0];
  assign dvd_neg_in    = div_signed_in && rs1_val[XLEN-1];
  assign dvd_mag_in    = dvd_neg_in ? -rs1_val : rs1_val;
  assign div_zero      = (rs2_val == '0);
  assign div_ovf       = div_signed_in && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
  assign special       = div_zero || div_ovf;

  // Multiply datapath on the latched operands
  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_res;

  assign a_sgn   = ((funct3_q == 3'd1) || (funct3_q == 3'd2)) && op_a[XLEN-1];
  assign b_sgn   = (funct3_q == 3'd1) && op_b[XLEN-1];
  assign product = {{XLEN{a_sgn}}, op_a} * {{XLEN{b_sgn}}, op_b};
  assign mul_res = (funct3_q == 3'd0) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // Restoring divide step: quotient bits shift into quot_q as dividend bits shift out
  logic [XLEN-1:0] dsr_mag, fix_res;
  logic [XLEN:0]   r_shift, r_sub;

  assign dsr_mag = (!funct3_q[0] && op_b[XLEN-1]) ? -op_b : op_b;
  assign r_shift = {rem_q, quot_q[XLEN-1]};
  assign r_sub   = r_shift - {1'b0, dsr_mag};
  assign fix_res = funct3_q[1] ? (r_neg ? -rem_q : rem_q) : (q_neg ? -quot_q : quot_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = (state == IDLE) && !bus.in_flush;
    bus.out_valid = (state == DONE) && !bus.in_flush;
    bus.out_busy  = (state != IDLE);
    case (state)
      IDLE: if (accept) state_nxt = !bus.in_funct3[2] ? MUL : (special ? FIX : DIV);
      MUL:  if (cnt == '0) state_nxt = DONE;
      DIV:  if (cnt == '0) state_nxt = FIX;
      FIX:  if (cnt == '0) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.in_flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct3_q <= '0;
      rd_q     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else if (accept) begin
      funct3_q <= bus.in_funct3;
      rd_q     <= bus.in_rd;
      op_a     <= rs1_val;
      op_b     <= rs2_val;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      if (!bus.in_funct3[2]) begin
        cnt <= CW'(MUL_LAT - 1);
      end else if (special) begin
        // Final values are known now; FIX dwells one extra cycle to give a fixed 2-cycle latency.
        cnt    <= CW'(1);
        quot_q <= div_zero ? '1 : rs1_val;
        rem_q  <= div_zero ? rs1_val : '0;
      end else begin
        cnt    <= CW'(XLEN - 1);
        quot_q <= dvd_mag_in;
        rem_q  <= '0;
        q_neg  <= div_signed_in && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
        r_neg  <= dvd_neg_in;
      end
    end else begin
      case (state)
        MUL: begin
          if (cnt == '0) result_q <= mul_res;
          else           cnt <= cnt - CW'(1);
        end
        DIV: begin
          if (!r_sub[XLEN]) begin
            rem_q  <= r_sub[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q  <= r_shift[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], 1'b0};
          end
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (cnt == '0) result_q <= fix_res;
          else           cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.out_result = result_q;
  assign bus.out_rd     = rd_q;

endmodule

// File: tb/tb_stage_execute_muldiv.sv
// Table-driven and randomized bench for stage_execute_muldiv against a plain-arithmetic RV32M model.
module tb_stage_execute_muldiv;
  localparam int XLEN = 32, NUM_FWD = 2, MUL_LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage_execute_muldiv_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) bus();
  stage_execute_muldiv #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2;
    logic [9:0]  frd;
    logic [1:0]  fwe;
    logic [63:0] fdat;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2, input logic [9:0] frd,
                               input logic [1:0] fwe, input logic [63:0] fdat, input logic [31:0] exp,
                               input int lat, input int hold);
    vec_t v;
    v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.d1 = d1; v.d2 = d2; v.frd = frd;
    v.fwe = fwe; v.fdat = fdat; v.exp = exp; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // Reference: youngest matching bypass source, never for x0
  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf,
                                          input logic [9:0] frd, input logic [1:0] fwe, input logic [63:0] fdat);
    for (int i = 0; i < NUM_FWD; i++)
      if (fwe[i] && frd[5*i +: 5] == rs && rs != 5'd0) return fdat[32*i +: 32];
    return rf;
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = 64'(sa) * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input vec_t v, input logic [4:0] rd);
    bus.in_funct3 = v.f3; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2;
    bus.in_data_rs1 = v.d1; bus.in_data_rs2 = v.d2; bus.in_rd = rd;
    bus.in_fwd_rd = v.frd; bus.in_fwd_we = v.fwe; bus.in_fwd_data = v.fdat;
    bus.in_valid = 1'b1;
  endtask

  task automatic run_op(input vec_t v, input logic [4:0] rd, input string tag);
    int n;
    @(negedge clk);
    drive(v, rd);
    chk({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, " busy after accept"}, 64'(bus.out_busy), 64'd1);
    n = 0;
    while (n < 100 && !bus.out_valid) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(v.lat));
    chk({tag, " result"}, 64'(bus.out_result), 64'(v.exp));
    chk({tag, " rd"}, 64'(bus.out_rd), 64'(rd));
    chk({tag, " in_ready in done"}, 64'(bus.in_ready), 64'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid/ready"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
      chk({tag, " hold result"}, 64'(bus.out_result), 64'(v.exp));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " valid/busy after handshake"}, {62'd0, bus.out_valid, bus.out_busy}, 64'd0);
  endtask

  initial begin
    vec_t v;
    int   seen;
    logic [31:0] a, b;

    tbl.push_back(mkv(3'd0, 5'd5, 5'd5, 32'd100, 32'd200, {5'd5, 5'd5}, 2'b11, {32'd7, 32'd9}, 32'd81, MUL_LAT, 0));
    tbl.push_back(mkv(3'd0, 5'd0, 5'd2, 32'd3, 32'd4, {5'd2, 5'd0}, 2'b11, {32'd6, 32'd55}, 32'd18, MUL_LAT, 1));
    tbl.push_back(mkv(3'd0, 5'd1, 5'd2, 32'hFFFF_FFFD, 32'd5, 10'd0, 2'b00, 64'd0, 32'hFFFF_FFF1, MUL_LAT, 0));
    tbl.push_back(mkv(3'd1, 5'd1, 5'd2, 32'h8000_0000, 32'h8000_0000, 10'd0, 2'b00, 64'd0, 32'h4000_0000, MUL_LAT, 0));
    tbl.push_back(mkv(3'd2, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10'd0, 2'b00, 64'd0, 32'hFFFF_FFFF, MUL_LAT, 0));
    tbl.push_back(mkv(3'd3, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10'd0, 2'b00, 64'd0, 32'hFFFF_FFFE, MUL_LAT, 0));
    tbl.push_back(mkv(3'd4, 5'd1, 5'd2, 32'd20, 32'd0, 10'd0, 2'b00, 64'd0, 32'hFFFF_FFFF, 2, 0));
    tbl.push_back(mkv(3'd6, 5'd1, 5'd2, 32'd20, 32'd0, 10'd0, 2'b00, 64'd0, 32'd20, 2, 0));
    tbl.push_back(mkv(3'd5, 5'd1, 5'd2, 32'd20, 32'd0, 10'd0, 2'b00, 64'd0, 32'hFFFF_FFFF, 2, 0));
    tbl.push_back(mkv(3'd7, 5'd1, 5'd2, 32'd20, 32'd0, 10'd0, 2'b00, 64'd0, 32'd20, 2, 0));
    tbl.push_back(mkv(3'd4, 5'd1, 5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10'd0, 2'b00, 64'd0, 32'h8000_0000, 2, 0));
    tbl.push_back(mkv(3'd6, 5'd1, 5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10'd0, 2'b00, 64'd0, 32'd0, 2, 0));
    tbl.push_back(mkv(3'd4, 5'd1, 5'd2, 32'hFFFF_FFF9, 32'd2, 10'd0, 2'b00, 64'd0, 32'hFFFF_FFFD, 33, 0));
    tbl.push_back(mkv(3'd6, 5'd1, 5'd2, 32'hFFFF_FFF9, 32'd2, 10'd0, 2'b00, 64'd0, 32'hFFFF_FFFF, 33, 0));
    tbl.push_back(mkv(3'd5, 5'd1, 5'd2, 32'd100, 32'd7, 10'd0, 2'b00, 64'd0, 32'd14, 33, 5));
    tbl.push_back(mkv(3'd7, 5'd1, 5'd2, 32'd100, 32'd7, 10'd0, 2'b00, 64'd0, 32'd2, 33, 0));

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_data_rs1 = '0; bus.in_data_rs2 = '0; bus.in_rd = '0;
    bus.in_fwd_rd = '0; bus.in_fwd_we = '0; bus.in_fwd_data = '0;
    bus.in_flush = 1'b0; bus.out_ready = 1'b0;
    #1;
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset valid/busy", {62'd0, bus.out_valid, bus.out_busy}, 64'd0);
    chk("reset result", 64'(bus.out_result), 64'd0);
    chk("reset rd", 64'(bus.out_rd), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i], 5'(i + 1), $sformatf("vec%0d", i));

    // Flush during divide iteration 10, with a competing request that must not be taken
    run_op(mkv(3'd0, 5'd1, 5'd2, 32'd6, 32'd7, 10'd0, 2'b00, 64'd0, 32'd42, MUL_LAT, 0), 5'd9, "pre-flush");
    @(negedge clk);
    drive(mkv(3'd5, 5'd1, 5'd2, 32'd1000, 32'd3, 10'd0, 2'b00, 64'd0, 32'd0, 0, 0), 5'd4);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    drive(mkv(3'd0, 5'd1, 5'd2, 32'd2, 32'd2, 10'd0, 2'b00, 64'd0, 32'd0, 0, 0), 5'd5);
    bus.in_flush = 1'b1;
    #1;
    chk("flush in_ready", 64'(bus.in_ready), 64'd0);
    chk("flush out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    bus.in_flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush to idle valid/busy", {62'd0, bus.out_valid, bus.out_busy}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.out_busy) seen = 1;
    end
    chk("flush no result", 64'(seen), 64'd0);
    run_op(mkv(3'd5, 5'd1, 5'd2, 32'd1000, 32'd3, 10'd0, 2'b00, 64'd0, 32'd333, 33, 1), 5'd6, "post-flush");

    // Asynchronous reset in the middle of a multiply
    run_op(mkv(3'd0, 5'd1, 5'd2, 32'd6, 32'd7, 10'd0, 2'b00, 64'd0, 32'd42, MUL_LAT, 0), 5'd9, "pre-reset");
    @(negedge clk);
    drive(mkv(3'd0, 5'd1, 5'd2, 32'd3, 32'd4, 10'd0, 2'b00, 64'd0, 32'd0, 0, 0), 5'd17);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async reset valid/busy", {62'd0, bus.out_valid, bus.out_busy}, 64'd0);
    chk("async reset result", 64'(bus.out_result), 64'd0);
    chk("async reset rd", 64'(bus.out_rd), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    repeat (MUL_LAT + 3) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    chk("reset discards op", 64'(seen), 64'd0);

    // Randomized operations with collision-prone bypass indices
    for (int i = 0; i < 40; i++) begin
      v.f3   = 3'($urandom_range(0, 7));
      v.rs1  = 5'($urandom_range(0, 3));
      v.rs2  = 5'($urandom_range(0, 3));
      v.d1   = pick();
      v.d2   = pick();
      v.frd  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      v.fwe  = 2'($urandom_range(0, 3));
      v.fdat = {pick(), pick()};
      a      = ref_fwd(v.rs1, v.d1, v.frd, v.fwe, v.fdat);
      b      = ref_fwd(v.rs2, v.d2, v.frd, v.fwe, v.fdat);
      v.exp  = ref_op(v.f3, a, b);
      v.lat  = ref_lat(v.f3, a, b);
      v.hold = $urandom_range(0, 2);
      run_op(v, 5'($urandom_range(1, 31)), $sformatf("rnd%0d f3=%0d a=%0h b=%0h", i, v.f3, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
